// File: rtl/issue_control_unit.sv
// rtl/issue_control_unit.sv - registered, handshaked opcode decoder with multi-cycle hold, flush and illegal counting
// One opcode per cycle from fetch becomes a registered control word for execute.

module issue_control_unit #(
    parameter int OPCODE_W  = 5,
    parameter int ENABLE_MD = 1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 8,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                RegWrite,
    output logic                ResultSrc,
    output logic                MemWrite,
    output logic                Jump,
    output logic                ALUSrc,
    output logic                Cant_Byte,
    output logic [1:0]          Branch,
    output logic [2:0]          ALUControl,
    output logic [1:0]          ImmSrc,
    output logic                busy,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int LAT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
    localparam bit MUL_MC  = (MUL_LAT > 1);
    localparam bit DIV_MC  = (DIV_LAT > 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       jump;
        logic       alu_src;
        logic       cant_byte;
        logic [1:0] branch;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
    } ctrl_t;

    state_t             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic               held_mul_q, held_mul_d;
    logic               held_div_q, held_div_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    ctrl_t              dec;
    logic               dec_hit;
    logic               dec_mul;
    logic               dec_div;
    logic               dec_legal;
    logic               upper_ok;
    logic               held_multi;
    logic               accept;

    assign upper_ok = ((Opcode >> 5) == '0);

    always_comb begin
        dec     = '0;
        dec_hit = 1'b1;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (Opcode[4:0])
            5'b00000, 5'b00111, 5'b01000: dec.reg_write = 1'b1;
            5'b00010: begin dec.reg_write = 1'b1; dec.alu_ctrl = 3'b001; end
            5'b00011: begin dec.reg_write = 1'b1; dec.alu_ctrl = 3'b010; dec_mul = 1'b1; end
            5'b00100: begin dec.reg_write = 1'b1; dec.alu_ctrl = 3'b011; dec_div = 1'b1; end
            5'b00101: begin dec.reg_write = 1'b1; dec.alu_ctrl = 3'b100; dec_div = 1'b1; end
            5'b00001: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 2'b01;
            end
            5'b00110: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = 3'b101; dec.imm_src = 2'b01;
            end
            5'b01001: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = 3'b110; dec.imm_src = 2'b10;
            end
            5'b01010: begin dec.mem_write = 1'b1; dec.cant_byte = 1'b1; end
            5'b01011: dec.mem_write = 1'b1;
            5'b01100: begin dec.reg_write = 1'b1; dec.result_src = 1'b1; dec.cant_byte = 1'b1; end
            5'b01101: begin dec.reg_write = 1'b1; dec.result_src = 1'b1; end
            5'b10000: begin dec.jump = 1'b1; dec.imm_src = 2'b11; dec.alu_src = 1'b1; end
            5'b10001: dec.alu_ctrl = 3'b001;
            5'b10010: begin dec.branch = 2'b01; dec.imm_src = 2'b11; dec.alu_src = 1'b1; end
            5'b10011: begin dec.branch = 2'b10; dec.imm_src = 2'b11; dec.alu_src = 1'b1; end
            5'b10100: begin dec.branch = 2'b11; dec.imm_src = 2'b11; dec.alu_src = 1'b1; end
            default:  dec_hit = 1'b0;
        endcase
    end

    // MULT/DIV/MOD are only legal when the multi-cycle datapath exists.
    assign dec_legal = dec_hit & upper_ok & ((ENABLE_MD != 0) | ~(dec_mul | dec_div));

    // A single-cycle latency MULT/DIV behaves exactly like an ordinary op.
    assign held_multi = (held_mul_q & MUL_MC) | (held_div_q & DIV_MC);

    assign in_ready = ~flush & ((state_q == S_IDLE) |
                                ((state_q == S_HOLD) & out_ready & ~held_multi));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        held_mul_d    = held_mul_q;
        held_div_d    = held_div_q;
        cnt_d         = cnt_q;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && dec_legal) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (held_multi) begin
                            state_d = S_WAIT;
                            cnt_d   = held_mul_q ? LAT_W'(MUL_LAT - 1) : LAT_W'(DIV_LAT - 1);
                        end else if (accept && dec_legal) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= LAT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - LAT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (accept && dec_legal) begin
                ctrl_d     = dec;
                held_mul_d = dec_mul;
                held_div_d = dec_div;
            end
            if (accept && !dec_legal) begin
                illegal_d = 1'b1;
                if (illegal_cnt_q != '1) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end
        end

        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ctrl_q        <= '0;
            held_mul_q    <= 1'b0;
            held_div_q    <= 1'b0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            held_mul_q    <= held_mul_d;
            held_div_q    <= held_div_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign illegal_op  = illegal_q;
    assign illegal_cnt = illegal_cnt_q;
    assign RegWrite    = ctrl_q.reg_write;
    assign ResultSrc   = ctrl_q.result_src;
    assign MemWrite    = ctrl_q.mem_write;
    assign Jump        = ctrl_q.jump;
    assign ALUSrc      = ctrl_q.alu_src;
    assign Cant_Byte   = ctrl_q.cant_byte;
    assign Branch      = ctrl_q.branch;
    assign ALUControl  = ctrl_q.alu_ctrl;
    assign ImmSrc      = ctrl_q.imm_src;

endmodule

// File: tb/tb_issue_control_unit.sv
// tb/tb_issue_control_unit.sv - self-checking bench for issue_control_unit
// Directed vectors for the corner cases, then random traffic against a table-driven reference model.

module tb_issue_control_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic       rw;
        logic       rs;
        logic       mw;
        logic       jmp;
        logic       asrc;
        logic       cb;
        logic [1:0] br;
        logic [2:0] aluc;
        logic [1:0] imm;
    } ctrl_t;

    typedef struct {
        bit         iv;
        logic [4:0] op;
        bit         fl;
        bit         ordy;
        bit         e_ready;
        bit         e_valid;
        bit         e_busy;
        logic [2:0] e_aluc;
        bit         e_asrc;
        bit         e_rs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, flush, out_ready;
    logic [4:0] Opcode;
    logic       in_ready, out_valid, busy, illegal_op;
    logic       RegWrite, ResultSrc, MemWrite, Jump, ALUSrc, Cant_Byte;
    logic [1:0] Branch, ImmSrc;
    logic [2:0] ALUControl;
    logic [7:0] illegal_cnt;

    logic       in_valid1, flush1, out_ready1;
    logic [5:0] Opcode1;
    logic       in_ready1, out_valid1, busy1, illegal_op1;
    logic       RegWrite1, ResultSrc1, MemWrite1, Jump1, ALUSrc1, Cant_Byte1;
    logic [1:0] Branch1, ImmSrc1;
    logic [2:0] ALUControl1;
    logic [7:0] illegal_cnt1;

    always #5 clk = ~clk;

    issue_control_unit #(.OPCODE_W(5), .ENABLE_MD(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .Opcode(Opcode),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .MemWrite(MemWrite), .Jump(Jump),
        .ALUSrc(ALUSrc), .Cant_Byte(Cant_Byte), .Branch(Branch), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .busy(busy), .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
    );

    issue_control_unit #(.OPCODE_W(6), .ENABLE_MD(0), .MUL_LAT(2), .DIV_LAT(8), .CNT_W(8)) dut_nomd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .Opcode(Opcode1),
        .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1),
        .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .MemWrite(MemWrite1), .Jump(Jump1),
        .ALUSrc(ALUSrc1), .Cant_Byte(Cant_Byte1), .Branch(Branch1), .ALUControl(ALUControl1),
        .ImmSrc(ImmSrc1), .busy(busy1), .illegal_op(illegal_op1), .illegal_cnt(illegal_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode table, filled from the opcode list.
    ctrl_t ref_dec [32];
    bit    ref_legal [32];

    task automatic def(input int op, input bit rw, input bit rs, input bit mw, input bit j,
                       input bit as, input bit cb, input logic [1:0] br,
                       input logic [2:0] aluc, input logic [1:0] imm);
        ref_legal[op] = 1'b1;
        ref_dec[op]   = {rw, rs, mw, j, as, cb, br, aluc, imm};
    endtask

    task automatic init_table();
        for (int i = 0; i < 32; i++) begin
            ref_legal[i] = 1'b0;
            ref_dec[i]   = '0;
        end
        def(5'b00000, 1,0,0,0,0,0, 2'b00, 3'b000, 2'b00);
        def(5'b00111, 1,0,0,0,0,0, 2'b00, 3'b000, 2'b00);
        def(5'b01000, 1,0,0,0,0,0, 2'b00, 3'b000, 2'b00);
        def(5'b00010, 1,0,0,0,0,0, 2'b00, 3'b001, 2'b00);
        def(5'b00011, 1,0,0,0,0,0, 2'b00, 3'b010, 2'b00);
        def(5'b00100, 1,0,0,0,0,0, 2'b00, 3'b011, 2'b00);
        def(5'b00101, 1,0,0,0,0,0, 2'b00, 3'b100, 2'b00);
        def(5'b00001, 1,0,0,0,1,0, 2'b00, 3'b000, 2'b01);
        def(5'b00110, 1,0,0,0,1,0, 2'b00, 3'b101, 2'b01);
        def(5'b01001, 1,0,0,0,1,0, 2'b00, 3'b110, 2'b10);
        def(5'b01010, 0,0,1,0,0,1, 2'b00, 3'b000, 2'b00);
        def(5'b01011, 0,0,1,0,0,0, 2'b00, 3'b000, 2'b00);
        def(5'b01100, 1,1,0,0,0,1, 2'b00, 3'b000, 2'b00);
        def(5'b01101, 1,1,0,0,0,0, 2'b00, 3'b000, 2'b00);
        def(5'b10000, 0,0,0,1,1,0, 2'b00, 3'b000, 2'b11);
        def(5'b10001, 0,0,0,0,0,0, 2'b00, 3'b001, 2'b00);
        def(5'b10010, 0,0,0,0,1,0, 2'b01, 3'b000, 2'b11);
        def(5'b10011, 0,0,0,0,1,0, 2'b10, 3'b000, 2'b11);
        def(5'b10100, 0,0,0,0,1,0, 2'b11, 3'b000, 2'b11);
    endtask

    // Behavioural model: whether a word is held, how many stall cycles remain, what was last issued.
    bit    m_hold;
    int    m_wait;
    ctrl_t m_word;
    int    m_held_op;
    bit    m_ill;
    int    m_cnt;

    function automatic int op_lat(input int op);
        if (op == 3) return MUL_LAT;
        if (op == 4 || op == 5) return DIV_LAT;
        return 1;
    endfunction

    function automatic bit m_ready(input bit fl, input bit ordy);
        return !fl && (m_wait == 0) && (!m_hold || (ordy && op_lat(m_held_op) == 1));
    endfunction

    task automatic model_step(input bit iv, input int op, input bit fl, input bit ordy);
        bit rdy;
        rdy   = m_ready(fl, ordy);
        m_ill = 1'b0;
        if (fl) begin
            m_hold = 1'b0;
            m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            if (m_hold && ordy) begin
                m_hold = 1'b0;
                m_wait = op_lat(m_held_op) - 1;
            end
            if (iv && rdy) begin
                if (ref_legal[op]) begin
                    m_hold    = 1'b1;
                    m_word    = ref_dec[op];
                    m_held_op = op;
                end else begin
                    m_ill = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    function automatic ctrl_t dut_word();
        return {RegWrite, ResultSrc, MemWrite, Jump, ALUSrc, Cant_Byte, Branch, ALUControl, ImmSrc};
    endfunction

    task automatic check_model();
        chk("rnd out_valid", out_valid, m_hold);
        chk("rnd busy", busy, m_wait > 0);
        chk("rnd illegal_op", illegal_op, m_ill);
        chk("rnd illegal_cnt", illegal_cnt, m_cnt);
        chk("rnd ctrl", dut_word(), m_word);
    endtask

    task automatic drive(input bit iv, input logic [4:0] op, input bit fl, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        Opcode    = op;
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        init_table();
        rst_n = 1'b0; in_valid = 0; Opcode = '0; flush = 0; out_ready = 0;
        in_valid1 = 0; Opcode1 = '0; flush1 = 0; out_ready1 = 1;

        // SUM, SUMI, LR back to back, then DIV with its stall window.
        vecs.push_back('{1, 5'b00000, 0, 1, 1, 1, 0, 3'b000, 0, 0});
        vecs.push_back('{1, 5'b00001, 0, 1, 1, 1, 0, 3'b000, 1, 0});
        vecs.push_back('{1, 5'b01100, 0, 1, 1, 1, 0, 3'b000, 0, 1});
        vecs.push_back('{0, 5'b00000, 0, 1, 1, 0, 0, 3'b000, 0, 1});
        vecs.push_back('{1, 5'b00100, 0, 1, 1, 1, 0, 3'b011, 0, 0});
        vecs.push_back('{1, 5'b00000, 0, 1, 0, 0, 1, 3'b011, 0, 0});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{1, 5'b00000, 0, 1, 0, 0, 1, 3'b011, 0, 0});
        vecs.push_back('{1, 5'b00000, 0, 1, 0, 0, 0, 3'b011, 0, 0});
        vecs.push_back('{1, 5'b00110, 0, 1, 1, 1, 0, 3'b101, 1, 0});
        vecs.push_back('{0, 5'b00000, 0, 1, 1, 0, 0, 3'b101, 1, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset illegal_op", illegal_op, 0);
        chk("reset illegal_cnt", illegal_cnt, 0);
        chk("reset ctrl", dut_word(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", in_ready, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].op, vecs[i].fl, vecs[i].ordy);
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ready);
            post_edge();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d ALUControl", i), ALUControl, vecs[i].e_aluc);
            chk($sformatf("vec%0d ALUSrc", i), ALUSrc, vecs[i].e_asrc);
            chk($sformatf("vec%0d ResultSrc", i), ResultSrc, vecs[i].e_rs);
        end

        // 301 illegal opcodes: counter saturates at 255.
        for (int k = 1; k <= 301; k++) begin
            drive(1, (k == 1) ? 5'b11111 : 5'b01111, 0, 1);
            chk("illegal in_ready", in_ready, 1);
            post_edge();
            chk("illegal pulse", illegal_op, 1);
            chk("illegal not issued", out_valid, 0);
            chk("illegal_cnt", illegal_cnt, (k < 255) ? k : 255);
        end
        drive(0, 5'b00000, 0, 1);
        post_edge();
        chk("illegal pulse ends", illegal_op, 0);
        chk("illegal_cnt held", illegal_cnt, 255);

        // SPE held under backpressure, then flush races a new opcode.
        drive(1, 5'b10100, 0, 0);
        post_edge();
        for (int k = 0; k < 4; k++) begin
            drive(0, 5'b00000, 0, 0);
            chk("spe hold in_ready", in_ready, 0);
            post_edge();
            chk("spe hold out_valid", out_valid, 1);
            chk("spe hold Branch", Branch, 2'b11);
            chk("spe hold ImmSrc", ImmSrc, 2'b11);
            chk("spe hold ALUSrc", ALUSrc, 1);
        end
        drive(1, 5'b00000, 1, 1);
        chk("flush in_ready", in_ready, 0);
        post_edge();
        chk("flush out_valid", out_valid, 0);
        chk("flush no accept Branch", Branch, 2'b11);
        drive(0, 5'b00000, 0, 1);
        post_edge();
        chk("after flush out_valid", out_valid, 0);

        // Reset lands while DIV is counting down at counter=3.
        drive(1, 5'b00100, 0, 1);
        post_edge();
        drive(0, 5'b00000, 0, 1);
        post_edge();
        chk("div wait busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 5'b00000, 0, 1);
            post_edge();
        end
        chk("div still busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst ctrl", dut_word(), 0);
        chk("async rst illegal_cnt", illegal_cnt, 0);
        chk("async rst illegal_op", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", in_ready, 1);

        // No multi-cycle datapath and 6-bit opcodes.
        @(negedge clk);
        in_valid1 = 1; Opcode1 = 6'b000011;
        post_edge();
        chk("nomd MULT illegal", illegal_op1, 1);
        chk("nomd MULT not issued", out_valid1, 0);
        @(negedge clk);
        Opcode1 = 6'b100000;
        post_edge();
        chk("w6 upper bit illegal", illegal_op1, 1);
        chk("w6 upper not issued", out_valid1, 0);
        chk("w6 illegal_cnt", illegal_cnt1, 2);
        @(negedge clk);
        Opcode1 = 6'b000000;
        post_edge();
        chk("w6 SUM issued", out_valid1, 1);
        chk("w6 SUM legal", illegal_op1, 0);
        @(negedge clk);
        in_valid1 = 0;

        // Random traffic against the reference model.
        m_hold = 0; m_wait = 0; m_word = '0; m_held_op = 0; m_ill = 0; m_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            bit         iv, fl, ordy;
            logic [4:0] op;
            iv   = ($urandom % 4) != 0;
            op   = ($urandom % 4 == 0) ? 5'($urandom_range(3, 5)) : 5'($urandom);
            fl   = ($urandom % 16) == 0;
            ordy = ($urandom % 3) != 0;
            drive(iv, op, fl, ordy);
            chk("rnd in_ready", in_ready, m_ready(fl, ordy));
            model_step(iv, int'(op), fl, ordy);
            post_edge();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
